// File: rtl/result_serializer.sv
// Serializes 16-bit result words through a one-deep holding register and a bit-indexed shifter.
// Optional parity bit per frame is compiled in with `define RESULT_SERIALIZER_PARITY_EN.
module result_serializer #(
  parameter bit          LSB_FIRST = 1'b1,
  parameter int unsigned GAP       = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic dst0,
  input  logic dst1,
  input  logic dst2,
  input  logic dst3,
  input  logic dst4,
  input  logic dst5,
  input  logic dst6,
  input  logic dst7,
  input  logic dst8,
  input  logic dst9,
  input  logic dst10,
  input  logic dst11,
  input  logic dst12,
  input  logic dst13,
  input  logic dst14,
  input  logic dst15,
  input  logic cap_valid,
  output logic cap_ready,
  output logic sout,
  output logic sout_valid,
  output logic sout_last,
  output logic busy
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
`ifdef RESULT_SERIALIZER_PARITY_EN
  localparam logic [1:0] ST_PARITY = 2'd2;
`endif
  localparam logic [1:0] ST_GAP    = 2'd3;

  localparam logic [3:0] GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  logic [15:0] word;
  logic [1:0]  state,     state_d;
  logic [15:0] hold,      hold_d;
  logic        hold_full, hold_full_d;
  logic [15:0] shifter,   shifter_d;
  logic [3:0]  cnt,       cnt_d;
  logic [3:0]  gap_cnt,   gap_cnt_d;
  logic        alive;
  logic        capture;
  logic        load;
  logic        frame_end;
  logic        data_bit;

  assign word = {dst15, dst14, dst13, dst12, dst11, dst10, dst9, dst8,
                 dst7,  dst6,  dst5,  dst4,  dst3,  dst2,  dst1, dst0};

  // alive keeps cap_ready low while in reset without a path from rst_n to the output.
  assign cap_ready = alive & ~hold_full;
  assign capture   = cap_valid & cap_ready;

  always_comb begin
    // NOTE: every variable gets a default first so no path can leave it unassigned (no latches).
    state_d     = state;
    hold_d      = hold;
    hold_full_d = hold_full;
    shifter_d   = shifter;
    cnt_d       = cnt;
    gap_cnt_d   = gap_cnt;
    load        = 1'b0;
    frame_end   = 1'b0;

    case (state)
      ST_IDLE: begin
        if (hold_full) load = 1'b1;
      end
      ST_SHIFT: begin
        if (cnt == 4'd15) begin
`ifdef RESULT_SERIALIZER_PARITY_EN
          state_d = ST_PARITY;
`else
          frame_end = 1'b1;
`endif
        end else begin
          cnt_d = cnt + 4'd1;
        end
      end
`ifdef RESULT_SERIALIZER_PARITY_EN
      ST_PARITY: begin
        frame_end = 1'b1;
      end
`endif
      ST_GAP: begin
        if (gap_cnt == GAP_LAST) begin
          if (hold_full) load = 1'b1;
          else           state_d = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt + 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Successor of the last frame bit: optional gap, else straight reload or idle.
    if (frame_end) begin
      if (GAP > 0) begin
        state_d   = ST_GAP;
        gap_cnt_d = 4'd0;
      end else if (hold_full) begin
        load = 1'b1;
      end else begin
        state_d = ST_IDLE;
      end
    end

    if (load) begin
      shifter_d   = hold;
      hold_full_d = 1'b0;
      cnt_d       = 4'd0;
      state_d     = ST_SHIFT;
    end

    // Capture needs hold_full=0 and load needs hold_full=1, so they never collide.
    if (capture) begin
      hold_d      = word;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      hold_full <= 1'b0;
      cnt       <= 4'd0;
      gap_cnt   <= 4'd0;
      alive     <= 1'b0;
      // NOTE: the data registers are cleared too, so reset leaves no stale word visible anywhere.
      hold      <= 16'd0;
      shifter   <= 16'd0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state     <= state_d;
      hold_full <= hold_full_d;
      cnt       <= cnt_d;
      gap_cnt   <= gap_cnt_d;
      alive     <= 1'b1;
      hold      <= hold_d;
      shifter   <= shifter_d;
    end
  end

  assign data_bit = LSB_FIRST ? shifter[cnt] : shifter[4'd15 - cnt];

  always_comb begin
    sout       = 1'b0;
    sout_valid = 1'b0;
    sout_last  = 1'b0;
    if (state == ST_SHIFT) begin
      sout_valid = 1'b1;
      sout       = data_bit;
`ifndef RESULT_SERIALIZER_PARITY_EN
      sout_last  = (cnt == 4'd15);
`endif
    end
`ifdef RESULT_SERIALIZER_PARITY_EN
    if (state == ST_PARITY) begin
      sout_valid = 1'b1;
      sout       = ^shifter;
      sout_last  = 1'b1;
    end
`endif
  end

  assign busy = (state != ST_IDLE) | hold_full;

endmodule

// File: tb/tb_result_serializer.sv
// Bench for result_serializer: instance a is LSB-first with no gap, instance b is MSB-first with GAP=3.
// Expected frame bits are queued at capture time and compared as the serial stream appears.
module tb_result_serializer;

`ifdef RESULT_SERIALIZER_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int FRAME = PAR_EN ? 17 : 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] w_a, w_b;
  logic        cv_a, cv_b;
  logic        cap_ready_a, sout_a, sout_valid_a, sout_last_a, busy_a;
  logic        cap_ready_b, sout_b, sout_valid_b, sout_last_b, busy_b;

  int n_cmp = 0;
  int n_bad = 0;

  logic [1:0] q_a[$];
  logic [1:0] q_b[$];
  int valid_run[2]      = '{0, 0};
  int idle_run[2]       = '{0, 0};
  int last_valid_run[2] = '{0, 0};
  int last_idle_run[2]  = '{0, 0};
  int frames[2]         = '{0, 0};

  always #5 clk = ~clk;

  result_serializer #(.LSB_FIRST(1'b1), .GAP(0)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .dst0(w_a[0]),   .dst1(w_a[1]),   .dst2(w_a[2]),   .dst3(w_a[3]),
    .dst4(w_a[4]),   .dst5(w_a[5]),   .dst6(w_a[6]),   .dst7(w_a[7]),
    .dst8(w_a[8]),   .dst9(w_a[9]),   .dst10(w_a[10]), .dst11(w_a[11]),
    .dst12(w_a[12]), .dst13(w_a[13]), .dst14(w_a[14]), .dst15(w_a[15]),
    .cap_valid(cv_a), .cap_ready(cap_ready_a),
    .sout(sout_a), .sout_valid(sout_valid_a), .sout_last(sout_last_a), .busy(busy_a)
  );

  result_serializer #(.LSB_FIRST(1'b0), .GAP(3)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .dst0(w_b[0]),   .dst1(w_b[1]),   .dst2(w_b[2]),   .dst3(w_b[3]),
    .dst4(w_b[4]),   .dst5(w_b[5]),   .dst6(w_b[6]),   .dst7(w_b[7]),
    .dst8(w_b[8]),   .dst9(w_b[9]),   .dst10(w_b[10]), .dst11(w_b[11]),
    .dst12(w_b[12]), .dst13(w_b[13]), .dst14(w_b[14]), .dst15(w_b[15]),
    .cap_valid(cv_b), .cap_ready(cap_ready_b),
    .sout(sout_b), .sout_valid(sout_valid_b), .sout_last(sout_last_b), .busy(busy_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference frame: 16 data bits in shift order, then the parity bit when compiled in.
  task automatic push_frame(input bit sel, input logic [15:0] word);
    logic [1:0] e;
    for (int i = 0; i < 16; i++) begin
      e[1] = sel ? word[15 - i] : word[i];
      e[0] = (i == 15) && !PAR_EN;
      if (sel) q_b.push_back(e);
      else     q_a.push_back(e);
    end
    if (PAR_EN) begin
      e = {^word, 1'b1};
      if (sel) q_b.push_back(e);
      else     q_a.push_back(e);
    end
  endtask

  task automatic mon(input bit sel, input logic s, input logic v, input logic l);
    logic [1:0] e;
    int         sz;
    if (v) begin
      if (valid_run[sel] == 0) last_idle_run[sel] = idle_run[sel];
      valid_run[sel]++;
      idle_run[sel] = 0;
      sz = sel ? q_b.size() : q_a.size();
      check(sel ? "b_bit_expected" : "a_bit_expected", 32'(sz != 0), 32'd1);
      if (sz != 0) begin
        e = sel ? q_b.pop_front() : q_a.pop_front();
        check(sel ? "b_sout" : "a_sout", 32'(s), 32'(e[1]));
        check(sel ? "b_sout_last" : "a_sout_last", 32'(l), 32'(e[0]));
      end
      if (l) frames[sel]++;
    end else begin
      if (valid_run[sel] > 0) last_valid_run[sel] = valid_run[sel];
      valid_run[sel] = 0;
      idle_run[sel]++;
      check(sel ? "b_idle_zero" : "a_idle_zero", 32'({s, l}), 32'd0);
    end
  endtask

  always @(negedge clk) begin
    mon(1'b0, sout_a, sout_valid_a, sout_last_a);
    mon(1'b1, sout_b, sout_valid_b, sout_last_b);
  end

  task automatic capture(input bit sel, input logic [15:0] word);
    @(negedge clk);
    for (int i = 0; i < 200 && !(sel ? cap_ready_b : cap_ready_a); i++) @(negedge clk);
    check(sel ? "b_cap_ready_wait" : "a_cap_ready_wait",
          32'(sel ? cap_ready_b : cap_ready_a), 32'd1);
    if (sel) begin w_b = word; cv_b = 1'b1; end
    else     begin w_a = word; cv_a = 1'b1; end
    @(posedge clk);
    push_frame(sel, word);
    #1;
    if (sel) cv_b = 1'b0;
    else     cv_a = 1'b0;
  endtask

  task automatic wait_idle(input bit sel);
    @(negedge clk);
    for (int i = 0; i < 400 && (sel ? busy_b : busy_a); i++) @(negedge clk);
    @(negedge clk);
    check(sel ? "b_drained" : "a_drained", 32'(sel ? busy_b : busy_a), 32'd0);
    check(sel ? "b_queue_empty" : "a_queue_empty",
          32'(sel ? q_b.size() : q_a.size()), 32'd0);
  endtask

  initial begin
    logic [15:0] words[3];
    int          frames_before;
    words = '{16'hA5A5, 16'h0007, 16'h0003};
    rst_n = 1'b0;
    w_a = 16'h0; w_b = 16'h0; cv_a = 1'b0; cv_b = 1'b0;

    // Reset state: all outputs low, including cap_ready.
    repeat (2) @(negedge clk);
    check("a_reset_outputs", 32'({cap_ready_a, busy_a, sout_valid_a, sout_a, sout_last_a}), 32'd0);
    check("b_reset_outputs", 32'({cap_ready_b, busy_b, sout_valid_b, sout_b, sout_last_b}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("a_ready_after_reset", 32'({cap_ready_a, busy_a}), 32'b10);
    check("b_ready_after_reset", 32'({cap_ready_b, busy_b}), 32'b10);

    // Single LSB-first frame 0x0001 with first-bit latency.
    capture(1'b0, 16'h0001);
    @(negedge clk);
    check("a_latency_cycle0", 32'({sout_valid_a, cap_ready_a, busy_a}), 32'b001);
    @(negedge clk);
    check("a_latency_cycle1_valid", 32'(sout_valid_a), 32'd1);
    wait_idle(1'b0);
    check("a_single_frame_len", 32'(last_valid_run[0]), 32'(FRAME));

    // Back-to-back: 0xFFFF held while 0x0000 shifts -> one unbroken run.
    capture(1'b0, 16'h0000);
    capture(1'b0, 16'hFFFF);
    wait_idle(1'b0);
    check("a_back_to_back_len", 32'(last_valid_run[0]), 32'(2 * FRAME));

    // Mixed patterns, including the parity cases 0x0007 and 0x0003.
    foreach (words[k]) begin
      capture(1'b0, words[k]);
      wait_idle(1'b0);
    end

    // MSB-first with GAP=3: two queued frames, then cap_valid held while not ready.
    frames_before = frames[1];
    capture(1'b1, 16'h8000);
    capture(1'b1, 16'hA5A5);
    @(negedge clk);
    w_b  = 16'hDEAD;
    cv_b = 1'b1;
    for (int i = 0; i < 200 && !cap_ready_b; i++) @(negedge clk);
    cv_b = 1'b0;
    check("b_ready_after_hold_wait", 32'(cap_ready_b), 32'd1);
    wait_idle(1'b1);
    check("b_frame_count", 32'(frames[1] - frames_before), 32'd2);
    check("b_gap_len", 32'(last_idle_run[1]), 32'd3);
    check("b_frame_len", 32'(last_valid_run[1]), 32'(FRAME));

    // Reset at cnt=7 with a second word held: frame abandoned, hold discarded.
    frames_before = frames[0];
    capture(1'b0, 16'h00FF);
    capture(1'b0, 16'h5555);
    repeat (6) @(posedge clk);
    #2;
    check("a_midframe_valid", 32'({sout_valid_a, busy_a}), 32'b11);
    rst_n = 1'b0;
    q_a.delete();
    #1;
    check("a_midreset_outputs", 32'({cap_ready_a, busy_a, sout_valid_a, sout_a, sout_last_a}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("a_after_release", 32'({cap_ready_a, busy_a, sout_valid_a}), 32'b100);
    check("a_no_last_on_abort", 32'(frames[0] - frames_before), 32'd0);

    // Recovery frame after reset.
    capture(1'b0, 16'h8001);
    wait_idle(1'b0);
    check("a_recovery_frame_len", 32'(last_valid_run[0]), 32'(FRAME));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
